// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_generator
//  Description : Parametrised VGA raster timing generator. A horizontal and a
//                vertical scan counter produce sync, blanking and line/frame
//                markers, all cycle-aligned with the counters.
//  Ports       : clk_25MHz    - pixel clock, rising edge
//                reset        - asynchronous, active-high
//                pixel_enable - advance tick; when low all state holds
//                restart      - synchronous return to raster origin
//                h_count      - horizontal position 0..H_TOTAL-1
//                v_count      - vertical position 0..V_TOTAL-1
//                hsync/vsync  - sync pulses, levels set by H_POL/V_POL
//                video_on     - high inside the active area
//                line_end     - single-edge pulse at the last pixel of a line
//                frame_end    - single-edge pulse at the last pixel of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CNT_W    = 10
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             pixel_enable,
    input  logic             restart,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_end
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(c_V_TOTAL - 1);

    // Decode bounds carry one extra bit so an exclusive upper bound equal to
    // 2**CNT_W is still representable.
    localparam logic [CNT_W:0] c_H_ACTIVE   = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] c_HS_START   = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] c_HS_END     = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] c_V_ACTIVE   = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] c_VS_START   = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] c_VS_END     = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic c_HS_ON = (H_POL != 0);
    localparam logic c_VS_ON = (V_POL != 0);

    generate
        if ((c_H_TOTAL > 2**CNT_W) || (c_V_TOTAL > 2**CNT_W)) begin : g_param_check
            $error("vga_timing_generator: CNT_W=%0d too small for H_TOTAL=%0d / V_TOTAL=%0d",
                   CNT_W, c_H_TOTAL, c_V_TOTAL);
        end
    endgenerate

    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;

    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_video_next;

    assign w_h_last = (r_h_count == c_H_LAST);
    assign w_v_last = (r_v_count == c_V_LAST);

    // Next raster position for an enabled edge (restart is handled in the
    // register block so it wins regardless of pixel_enable).
    always_comb begin
        w_h_next = r_h_count;
        w_v_next = r_v_count;
        if (pixel_enable) begin
            if (w_h_last) begin
                w_h_next = '0;
                w_v_next = w_v_last ? '0 : r_v_count + CNT_W'(1);
            end else begin
                w_h_next = r_h_count + CNT_W'(1);
            end
        end
    end

    // Decode from the next position so the registered sync/blank outputs line
    // up with the registered counters in the same cycle.
    always_comb begin
        w_hsync_next = ({1'b0, w_h_next} >= c_HS_START) && ({1'b0, w_h_next} < c_HS_END)
                     ? c_HS_ON : ~c_HS_ON;
        w_vsync_next = ({1'b0, w_v_next} >= c_VS_START) && ({1'b0, w_v_next} < c_VS_END)
                     ? c_VS_ON : ~c_VS_ON;
        w_video_next = ({1'b0, w_h_next} < c_H_ACTIVE) && ({1'b0, w_v_next} < c_V_ACTIVE);
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            r_h_count  <= '0;
            r_v_count  <= '0;
            r_hsync    <= ~c_HS_ON;
            r_vsync    <= ~c_VS_ON;
            r_video_on <= 1'b1;
        end else if (restart) begin
            r_h_count  <= '0;
            r_v_count  <= '0;
            r_hsync    <= ~c_HS_ON;
            r_vsync    <= ~c_VS_ON;
            r_video_on <= 1'b1;
        end else begin
            r_h_count  <= w_h_next;
            r_v_count  <= w_v_next;
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
            r_video_on <= w_video_next;
        end
    end

    assign h_count  = r_h_count;
    assign v_count  = r_v_count;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;

    // Markers are combinational so they are exactly one enabled edge wide.
    assign line_end  = w_h_last & pixel_enable & ~restart & ~reset;
    assign frame_end = line_end & w_v_last;

endmodule
`default_nettype wire
